instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Fetch stage feeding the instruction decoder: holds the PC and reads 32-bit words from
//  the instruction memory over a READ/BUSYWAIT handshake. Presents one instruction per
//  execute slot and computes the next PC (sequential, branch or jump, word offset).
//  Sits between instruction memory and the decode/control path of the 8-bit CPU.
// PARAMETERS
//  PC_W      32  PC width in bits (byte address)
//  IMEM_AW   8   instruction-memory word-address width (256 words = 1 KiB)
//  RESET_PC  0   PC value loaded on reset
// PORTS
//  CLK            in   1        clock; all state changes on posedge
//  RESET          in   1        asynchronous, active-high reset
//  BRANCH_TAKEN   in   1        control/ALU: conditional branch resolved taken, sampled in EXEC
//  JUMP           in   1        control: unconditional jump, sampled in EXEC
//  OFFSET         in   8        signed word offset from the executing instruction [23:16]
//  STALL          in   1        data-memory busywait; holds EXEC while high
//  IMEM_READ      out  1        read request to instruction memory
//  IMEM_ADDRESS   out  IMEM_AW  word address = PC[IMEM_AW+1:2]
//  IMEM_READDATA  in   32       instruction word, valid when READ=1 and BUSYWAIT=0
//  IMEM_BUSYWAIT  in   1        memory not ready; may assert combinationally with READ
//  INSTRUCTION    out  32       registered instruction word to the decoder
//  INSTR_VALID    out  1        1 while INSTRUCTION is the instruction executing this cycle
//  PC             out  PC_W     byte address of INSTRUCTION / of the pending fetch
// BEHAVIOUR
//  Reset (async, immediate): PC=RESET_PC, INSTRUCTION=32'h0, INSTR_VALID=0, IMEM_READ=0,
//   state=REQ. IMEM_READ rises on the first cycle after RESET deasserts.
//  FSM, two states:
//   REQ : IMEM_READ=1, INSTR_VALID=0. At posedge with IMEM_BUSYWAIT=0: INSTRUCTION<=IMEM_READDATA,
//         go EXEC. With BUSYWAIT=1: stay, hold READ and address stable.
//   EXEC: IMEM_READ=0, INSTR_VALID=1. At posedge with STALL=0: PC<=next_pc, go REQ.
//         With STALL=1: hold PC, INSTRUCTION, state; BRANCH_TAKEN/JUMP re-sampled at exit edge.
//  Minimum 2 cycles per instruction (zero-wait memory); +1 per BUSYWAIT cycle, +1 per STALL cycle.
//  next_pc: pc4 = PC+4; target = pc4 + {sext(OFFSET),2'b00} (sign-extend to PC_W, then shift).
//   next_pc = (JUMP | BRANCH_TAKEN) ? target : pc4. Both high -> target (same value).
//   All additions modulo 2^PC_W; 0xFFFFFFFC+4 wraps to 0. OFFSET=8'h80 -> -128 words.
//   OFFSET=8'hFF (-1 word) -> target = PC (self-loop).
//  PC[1:0] is always 00 by construction; IMEM_ADDRESS drops upper PC bits (wraps in memory).
//  BRANCH_TAKEN/JUMP/STALL/OFFSET are ignored in REQ.
//  RESET mid-fetch: READ drops asynchronously, fetched data discarded; memory must tolerate it.
//  IMEM_READDATA sampled only on the completing edge; X on other cycles is harmless.
//  Outputs are registered or decoded from state only (no comb path from inputs to outputs).
// STRUCTURE
//  Shared package cpu_pkg: INSTR_W=32, OFFSET_W=8, IMEM_AW default, fetch state enum
//   {FETCH_REQ, FETCH_EXEC}, RESET_PC default.
//  Sub-module pc_next_adder (combinational): inputs PC, OFFSET, take -> next_pc; reused by
//   the assertion model in the bench.
//  Top: PC register, instruction register, 1-bit state register, output decode.
// TESTING
//  T1 reset: RESET pulse mid-cycle -> PC=0, INSTR_VALID=0, IMEM_READ=0 at once; READ=1, ADDR=0 next cycle.
//  T2 sequential, zero-wait memory holding words 0..3 -> PC 0,4,8,12; INSTRUCTION matches each
//   word; INSTR_VALID every second cycle.
//  T3 BUSYWAIT 3 cycles on fetch at PC=8 -> READ held 4 cycles, ADDR=2 stable, capture on 4th edge.
//  T4 branch at PC=12, OFFSET=8'hFE, BRANCH_TAKEN=1 -> next PC=8; BRANCH_TAKEN=0 -> 16;
//   JUMP at PC=0, OFFSET=8'h02 -> 12; JUMP+BRANCH_TAKEN -> 12.
//  T5 STALL 2 cycles in EXEC at PC=4 -> PC/INSTRUCTION held, INSTR_VALID stays 1 for 3 cycles,
//   READ stays 0; then PC=8.
//  T6 wrap: RESET_PC=32'hFFFFFFFC, sequential -> PC=0, ADDR=0; reset during BUSYWAIT -> READ drops.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, reset defaults and fetch-state encoding for the 8-bit CPU.
package cpu_pkg;
    localparam int INSTR_W = 32;
    localparam int OFFSET_W = 8;
    localparam int PC_W = 32;
    localparam int IMEM_AW = 8;
    localparam logic [PC_W-1:0] RESET_PC = '0;
    typedef enum logic {FETCH_REQ, FETCH_EXEC} fetch_state_t;
endpackage

// File: rtl/pc_next_adder.sv
// pc_next_adder: next PC = PC+4, or PC+4 plus a signed word offset when a branch/jump is taken.
module pc_next_adder
    import cpu_pkg::*;
#(
    parameter int W = PC_W
) (
    input  logic [W-1:0]        pc,
    input  logic [OFFSET_W-1:0] offset,
    input  logic                take,
    output logic [W-1:0]        next_pc
);
    logic [W-1:0] pc4;
    logic [W-1:0] disp;
    assign pc4 = pc + W'(4);
    assign disp = {{(W-OFFSET_W-2){offset[OFFSET_W-1]}}, offset, 2'b00};
    assign next_pc = take ? pc4 + disp : pc4;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC/instruction registers and a REQ/EXEC fetch FSM over a READ/BUSYWAIT imem.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int              PC_W     = cpu_pkg::PC_W,
    parameter int              IMEM_AW  = cpu_pkg::IMEM_AW,
    parameter logic [PC_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                BRANCH_TAKEN,
    input  logic                JUMP,
    input  logic [OFFSET_W-1:0] OFFSET,
    input  logic                STALL,
    output logic                IMEM_READ,
    output logic [IMEM_AW-1:0]  IMEM_ADDRESS,
    input  logic [INSTR_W-1:0]  IMEM_READDATA,
    input  logic                IMEM_BUSYWAIT,
    output logic [INSTR_W-1:0]  INSTRUCTION,
    output logic                INSTR_VALID,
    output logic [PC_W-1:0]     PC
);
    fetch_state_t state;
    logic run;
    logic [PC_W-1:0] next_pc;

    pc_next_adder #(.W(PC_W)) u_adder (
        .pc(PC),
        .offset(OFFSET),
        .take(JUMP | BRANCH_TAKEN),
        .next_pc(next_pc)
    );

    // run keeps READ low until the first edge after reset releases
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= FETCH_REQ;
            run <= 1'b0;
            PC <= RESET_PC;
            INSTRUCTION <= '0;
        end else begin
            run <= 1'b1;
            if (state == FETCH_REQ) begin
                if (run && !IMEM_BUSYWAIT) begin
                    INSTRUCTION <= IMEM_READDATA;
                    state <= FETCH_EXEC;
                end
            end else if (!STALL) begin
                PC <= next_pc;
                state <= FETCH_REQ;
            end
        end
    end

    assign IMEM_READ = run && (state == FETCH_REQ);
    assign INSTR_VALID = (state == FETCH_EXEC);
    assign IMEM_ADDRESS = PC[IMEM_AW+1:2];
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed checks of fetch handshake, stalls, branches, jumps and PC wrap.
module tb_instruction_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic branch_taken = 1'b0;
    logic jump = 1'b0;
    logic [7:0] offset = 8'h00;
    logic stall = 1'b0;
    logic bw = 1'b0;
    logic read, read_w;
    logic [7:0] addr, addr_w;
    logic [31:0] rdata, rdata_w, instr, instr_w, pc, pc_w;
    logic valid, valid_w;
    logic [31:0] mem [256];
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;
    assign rdata = mem[addr];
    assign rdata_w = mem[addr_w];

    instruction_fetch_unit dut (
        .CLK(clk), .RESET(rst), .BRANCH_TAKEN(branch_taken), .JUMP(jump), .OFFSET(offset),
        .STALL(stall), .IMEM_READ(read), .IMEM_ADDRESS(addr), .IMEM_READDATA(rdata),
        .IMEM_BUSYWAIT(bw), .INSTRUCTION(instr), .INSTR_VALID(valid), .PC(pc)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .CLK(clk), .RESET(rst), .BRANCH_TAKEN(branch_taken), .JUMP(jump), .OFFSET(offset),
        .STALL(stall), .IMEM_READ(read_w), .IMEM_ADDRESS(addr_w), .IMEM_READDATA(rdata_w),
        .IMEM_BUSYWAIT(bw), .INSTRUCTION(instr_w), .INSTR_VALID(valid_w), .PC(pc_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("reset_pc", pc, 0);
        chk("reset_read", 32'(read), 0);
        chk("reset_valid", 32'(valid), 0);
        chk("reset_instr", instr, 0);
        chk("wrap_reset_pc", pc_w, 32'hFFFF_FFFC);
        tick();
        chk("first_read", 32'(read), 1);
        chk("first_addr", 32'(addr), 0);
        chk("first_valid", 32'(valid), 0);
        chk("wrap_addr_ff", 32'(addr_w), 32'hFF);
        tick();
        chk("seq0_instr", instr, 32'hA000_0000);
        chk("seq0_valid", 32'(valid), 1);
        chk("seq0_read", 32'(read), 0);
        chk("seq0_pc", pc, 0);
        chk("wrap_instr", instr_w, 32'hA000_00FF);
        tick();
        chk("seq1_pc", pc, 4);
        chk("seq1_addr", 32'(addr), 1);
        chk("seq1_valid", 32'(valid), 0);
        chk("wrap_pc0", pc_w, 0);
        chk("wrap_addr0", 32'(addr_w), 0);
        tick();
        chk("seq1_instr", instr, 32'hA000_0001);
        stall = 1'b1;
        tick();
        chk("stall1_pc", pc, 4);
        chk("stall1_instr", instr, 32'hA000_0001);
        chk("stall1_valid", 32'(valid), 1);
        chk("stall1_read", 32'(read), 0);
        tick();
        chk("stall2_pc", pc, 4);
        chk("stall2_valid", 32'(valid), 1);
        chk("stall2_read", 32'(read), 0);
        stall = 1'b0;
        tick();
        chk("post_stall_pc", pc, 8);
        chk("post_stall_read", 32'(read), 1);
        bw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("busy_read", 32'(read), 1);
            chk("busy_addr", 32'(addr), 2);
            chk("busy_valid", 32'(valid), 0);
        end
        chk("busy_no_capture", instr, 32'hA000_0001);
        bw = 1'b0;
        tick();
        chk("busy_capture", instr, 32'hA000_0002);
        chk("busy_capture_valid", 32'(valid), 1);
        tick();
        chk("seq3_pc", pc, 12);
        tick();
        chk("seq3_instr", instr, 32'hA000_0003);
        branch_taken = 1'b1;
        offset = 8'hFE;
        tick();
        chk("branch_back_pc", pc, 8);
        branch_taken = 1'b0;
        tick();
        tick();
        chk("back_seq_pc", pc, 12);
        tick();
        tick();
        chk("branch_not_taken_pc", pc, 16);
        jump = 1'b1;
        offset = 8'hFB;
        tick();
        tick();
        chk("jump_neg_pc", pc, 0);
        offset = 8'h02;
        tick();
        chk("jump_exec_instr", instr, 32'hA000_0000);
        tick();
        chk("jump_fwd_pc", pc, 12);
        offset = 8'hFC;
        tick();
        tick();
        chk("jump_to0_pc", pc, 0);
        branch_taken = 1'b1;
        offset = 8'h02;
        tick();
        tick();
        chk("jump_and_branch_pc", pc, 12);
        jump = 1'b0;
        offset = 8'h80;
        tick();
        tick();
        chk("offset_80_pc", pc, 32'hFFFF_FE10);
        chk("offset_80_addr", 32'(addr), 32'h84);
        tick();
        chk("offset_80_instr", instr, 32'hA000_0084);
        offset = 8'hFF;
        tick();
        chk("self_loop_pc", pc, 32'hFFFF_FE10);
        branch_taken = 1'b0;
        bw = 1'b1;
        tick();
        chk("pre_reset_read", 32'(read), 1);
        #3 rst = 1'b1;
        #1;
        chk("midreset_read", 32'(read), 0);
        chk("midreset_pc", pc, 0);
        chk("midreset_valid", 32'(valid), 0);
        chk("midreset_instr", instr, 0);
        chk("midreset_wrap_pc", pc_w, 32'hFFFF_FFFC);
        bw = 1'b0;
        #2 rst = 1'b0;
        tick();
        chk("rerun_read", 32'(read), 1);
        chk("rerun_addr", 32'(addr), 0);
        tick();
        chk("rerun_instr", instr, 32'hA000_0000);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
